// File: rtl/educell_token_sched_pkg.sv
// rtl/educell_token_sched_pkg.sv - shared widths, state encoding and propagation defaults
package educell_token_sched_pkg;

  localparam int TKROWADDR_BW = 2;
  localparam int NUM_ROWS     = 2 ** TKROWADDR_BW;

  localparam int DEF_PROP_BW  = 8;
  localparam int DEF_MIN_PROP = 2;
  localparam int DEF_MAX_PROP = 200;

  typedef enum logic [2:0] {
    EDUSCHED_IDLE  = 3'd0,
    EDUSCHED_CLEAR = 3'd1,
    EDUSCHED_PROP  = 3'd2,
    EDUSCHED_EMIT  = 3'd3,
    EDUSCHED_ADV   = 3'd4,
    EDUSCHED_DONE  = 3'd5
  } edusched_state_e;

endpackage

// File: rtl/educell_prop_timer.sv
// rtl/educell_prop_timer.sv - saturating propagation counter with min-settle and timeout flags
module educell_prop_timer #(
  parameter int PROP_BW  = 8,
  parameter int MIN_PROP = 2,
  parameter int MAX_PROP = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_en,
  output logic [PROP_BW-1:0] o_cnt,
  output logic               o_ge_min,
  output logic               o_at_timeout
);

  localparam logic [PROP_BW-1:0] L_MIN = PROP_BW'(MIN_PROP);
  localparam logic [PROP_BW-1:0] L_MAX = PROP_BW'(MAX_PROP);
  localparam logic [PROP_BW-1:0] L_TO  = PROP_BW'(MAX_PROP - 1);

  logic [PROP_BW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_ge_min     = (r_cnt >= L_MIN);
  assign o_at_timeout = (r_cnt == L_TO);

endmodule

// File: rtl/educell_token_sched.sv
// rtl/educell_token_sched.sv - token sweep sequencer for the EDU cell array
// Outputs are registered from the next state so they line up with the state they describe.
module educell_token_sched
  import educell_token_sched_pkg::*;
#(
  parameter int PROP_BW  = DEF_PROP_BW,
  parameter int MIN_PROP = DEF_MIN_PROP,
  parameter int MAX_PROP = DEF_MAX_PROP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TKROWADDR_BW:0]   num_rows,
  output logic [TKROWADDR_BW-1:0] curr_rowidx,
  output logic                    flag_token,
  output logic                    rst_cellstate,
  input  logic                    any_synk,
  input  logic                    any_spike,
  output logic                    match_valid,
  input  logic                    match_ready,
  output logic [TKROWADDR_BW-1:0] match_rowidx,
  output logic                    match_flag,
  output logic [PROP_BW-1:0]      match_lat,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);

  localparam logic [TKROWADDR_BW:0] L_MAX_ROWS = (TKROWADDR_BW + 1)'(NUM_ROWS);

  edusched_state_e r_state, w_next;

  logic [TKROWADDR_BW:0]   r_nrows;
  logic [TKROWADDR_BW-1:0] r_row;
  logic                    r_flag;
  logic                    r_rst_cell;
  logic                    r_mvalid;
  logic [TKROWADDR_BW-1:0] r_mrow;
  logic                    r_mflag;
  logic [PROP_BW-1:0]      r_mlat;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_timeout;

  logic [TKROWADDR_BW:0]   w_nrows_clamped;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_timeout_hit;
  logic [PROP_BW-1:0]      w_cnt;
  logic                    w_ge_min;
  logic                    w_at_timeout;

  educell_prop_timer #(
    .PROP_BW  (PROP_BW),
    .MIN_PROP (MIN_PROP),
    .MAX_PROP (MAX_PROP)
  ) u_prop_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_next == EDUSCHED_CLEAR),
    .i_en         (w_next == EDUSCHED_PROP),
    .o_cnt        (w_cnt),
    .o_ge_min     (w_ge_min),
    .o_at_timeout (w_at_timeout)
  );

  assign w_nrows_clamped = (num_rows > L_MAX_ROWS) ? L_MAX_ROWS : num_rows;
  // Last-position test happens before any increment, so row never wraps.
  assign w_last = r_flag && ({1'b0, r_row} == (r_nrows - 1'b1));

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      EDUSCHED_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (w_nrows_clamped == '0) ? EDUSCHED_DONE : EDUSCHED_CLEAR;
        end
      end
      EDUSCHED_CLEAR: w_next = EDUSCHED_PROP;
      EDUSCHED_PROP: begin
        if (any_synk) begin
          w_capture = 1'b1;
          w_next    = EDUSCHED_EMIT;
        end else if (!any_spike && w_ge_min) begin
          w_next = EDUSCHED_ADV;
        end else if (w_at_timeout) begin
          w_timeout_hit = 1'b1;
          w_next        = EDUSCHED_ADV;
        end
      end
      EDUSCHED_EMIT: begin
        if (match_ready) w_next = EDUSCHED_ADV;
      end
      EDUSCHED_ADV:  w_next = w_last ? EDUSCHED_DONE : EDUSCHED_CLEAR;
      EDUSCHED_DONE: w_next = EDUSCHED_IDLE;
      default:       w_next = EDUSCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EDUSCHED_IDLE;
      r_nrows    <= '0;
      r_row      <= '0;
      r_flag     <= 1'b0;
      r_rst_cell <= 1'b0;
      r_mvalid   <= 1'b0;
      r_mrow     <= '0;
      r_mflag    <= 1'b0;
      r_mlat     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != EDUSCHED_IDLE);
      r_done     <= (w_next == EDUSCHED_DONE);
      r_rst_cell <= (w_next == EDUSCHED_CLEAR);
      r_mvalid   <= (w_next == EDUSCHED_EMIT);
      if (w_accept) begin
        r_nrows   <= w_nrows_clamped;
        r_row     <= '0;
        r_flag    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
      if (w_capture) begin
        r_mrow  <= r_row;
        r_mflag <= r_flag;
        r_mlat  <= w_cnt;
      end
      if ((r_state == EDUSCHED_ADV) && !w_last) begin
        if (!r_flag) begin
          r_flag <= 1'b1;
        end else begin
          r_flag <= 1'b0;
          r_row  <= r_row + 1'b1;
        end
      end
    end
  end

  assign curr_rowidx   = r_row;
  assign flag_token    = r_flag;
  assign rst_cellstate = r_rst_cell;
  assign match_valid   = r_mvalid;
  assign match_rowidx  = r_mrow;
  assign match_flag    = r_mflag;
  assign match_lat     = r_mlat;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_timeout;

endmodule
